irq_priority_ctrl: RTL and testbench

Multi-source interrupt controller for the Interrupt subsystem.
- Each source passes through a two-flop rising-edge detector and sets a per-source pending latch.
- Enabled pending sources are arbitrated, and the winner is presented to the CPU over a request/ack/end-of-interrupt (EOI) handshake.
- Sits between peripheral interrupt lines and the core's single interrupt input.

---
 rtl/irq_ctrl_pkg.sv | 32 +++
 rtl/irq_arbiter.sv | 50 +++++
 rtl/irq_priority_ctrl.sv | 154 +++++++++++++++
 tb/tb_irq_priority_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared types and helpers for the interrupt priority controller.
//   irq_state_e      : controller FSM state (IDLE, REQ, SERVICE)
//   DEFAULT_NUM_SRC  : default number of interrupt sources
//   lowest_set_idx() : index of the lowest set bit of a 32-bit vector
// Optional feature macro used by the files importing this package:
//   IRQ_ROUND_ROBIN_EN (round-robin arbitration instead of fixed priority)
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

    localparam int DEFAULT_NUM_SRC = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // Returns 0 when no bit is set; callers qualify with their own valid flag.
    function automatic int lowest_set_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_arbiter.sv
// -----------------------------------------------------------------------------
// irq_arbiter
// Combinational winner selection among candidate interrupt sources.
// Macro IRQ_ROUND_ROBIN_EN:
//   undefined : fixed priority, lowest index wins
//   defined   : round-robin, search starts one above ptr_i and wraps
// Ports:
//   cand_i  [NUM_SRC] : candidate vector (pending & enabled)
//   ptr_i   [ID_W]    : last granted ID (round-robin build only)
//   win_o   [ID_W]    : winning source ID, meaningful when valid_o=1
//   valid_o           : at least one candidate present
// -----------------------------------------------------------------------------
module irq_arbiter
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = DEFAULT_NUM_SRC,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] cand_i,
`ifdef IRQ_ROUND_ROBIN_EN
    input  logic [ID_W-1:0]    ptr_i,
`endif
    output logic [ID_W-1:0]    win_o,
    output logic               valid_o
);

    assign valid_o = |cand_i;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [NUM_SRC-1:0] w_hi_mask;
    logic [NUM_SRC-1:0] w_masked;

    // Bits strictly above ptr_i. When ptr_i is the top index the shift
    // overflows to zero, the mask becomes empty and the search wraps to bit 0.
    assign w_hi_mask = ~((NUM_SRC'(2) << ptr_i) - NUM_SRC'(1));
    assign w_masked  = cand_i & w_hi_mask;

    always_comb begin
        win_o = '0;
        if (|w_masked) begin
            win_o = ID_W'(lowest_set_idx(32'(w_masked)));
        end else begin
            win_o = ID_W'(lowest_set_idx(32'(cand_i)));
        end
    end
`else
    assign win_o = ID_W'(lowest_set_idx(32'(cand_i)));
`endif

endmodule

// File: rtl/irq_priority_ctrl.sv
// -----------------------------------------------------------------------------
// irq_priority_ctrl
// Multi-source interrupt controller. Each raw line goes through a two-flop
// rising-edge detector that sets a per-source pending latch; enabled pending
// sources are arbitrated and the winner is offered to the CPU.
//
// Handshake (valid/ready style): irq_o is the valid; it rises with irq_id_o
// already stable and both hold until the CPU returns irq_ack_i (the ready).
// The transfer happens on the clock where irq_o=1 and irq_ack_i=1. The CPU
// then signals completion with irq_eoi_i while irq_busy_o=1. ack outside REQ
// and eoi outside SERVICE are ignored; ack+eoi together in REQ take only ack.
//
// Macro IRQ_ROUND_ROBIN_EN: round-robin arbitration with a last-granted
// pointer; undefined gives fixed priority (lowest index wins).
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   irq_src_i  [NUM_SRC]   : raw interrupt lines, rising edge = event
//   irq_en_i   [NUM_SRC]   : per-source enable mask
//   irq_o                  : interrupt request to CPU
//   irq_id_o   [ID_W]      : ID of requested / serviced source
//   irq_ack_i, irq_eoi_i   : CPU accept and end-of-interrupt
//   irq_busy_o             : high while in SERVICE
//   pending_o  [NUM_SRC]   : pending latches
//   ovf_o      [NUM_SRC]   : sticky overflow (edge while already pending)
//   dbg_state_o            : current FSM state
// -----------------------------------------------------------------------------
module irq_priority_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = DEFAULT_NUM_SRC,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic [NUM_SRC-1:0] irq_en_i,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o,
    input  logic               irq_ack_i,
    input  logic               irq_eoi_i,
    output logic               irq_busy_o,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [NUM_SRC-1:0] ovf_o,
    output irq_state_e         dbg_state_o
);

    logic [NUM_SRC-1:0] r_s1;
    logic [NUM_SRC-1:0] r_s2;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_ovf;
    irq_state_e         r_state;
    logic               r_irq;
    logic               r_busy;
    logic [ID_W-1:0]    r_id;

    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_cand;
    logic [NUM_SRC-1:0] w_clr;
    logic               w_ack_take;
    logic [ID_W-1:0]    w_win;
    logic               w_valid;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0]    r_ptr;
`endif

    assign w_edge     = r_s1 & ~r_s2;
    assign w_cand     = r_pending & irq_en_i;
    assign w_ack_take = (r_state == REQ) && irq_ack_i;
    assign w_clr      = w_ack_take ? (NUM_SRC'(1) << r_id) : '0;

    irq_arbiter #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_arb (
        .cand_i  (w_cand),
`ifdef IRQ_ROUND_ROBIN_EN
        .ptr_i   (r_ptr),
`endif
        .win_o   (w_win),
        .valid_o (w_valid)
    );

    // Edge detector, pending and overflow latches. A new edge in the clearing
    // cycle re-sets pending (set wins) but does not count as an overflow,
    // since the previous event is being consumed on that same clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_pending <= '0;
            r_ovf     <= '0;
        end else begin
            r_s1      <= irq_src_i;
            r_s2      <= r_s1;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            r_ovf     <= (r_ovf & ~w_clr) | (w_edge & r_pending & ~w_clr);
        end
    end

    // Request/service FSM with registered outputs. irq_id_o is latched only
    // in IDLE, so masking or new edges cannot disturb an outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
            r_busy  <= 1'b0;
            r_id    <= '0;
`ifdef IRQ_ROUND_ROBIN_EN
            r_ptr   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_id    <= w_win;
                        r_irq   <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack_i) begin
                        r_irq   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SERVICE;
`ifdef IRQ_ROUND_ROBIN_EN
                        r_ptr   <= r_id;
`endif
                    end
                end
                SERVICE: begin
                    if (irq_eoi_i) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_irq   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign irq_o       = r_irq;
    assign irq_id_o    = r_id;
    assign irq_busy_o  = r_busy;
    assign pending_o   = r_pending;
    assign ovf_o       = r_ovf;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_priority_ctrl
// Self-checking bench for irq_priority_ctrl. Expected grant IDs are queued
// when sources are raised and compared when the request is acknowledged.
// Build with IRQ_ROUND_ROBIN_EN defined to check the round-robin order.
// -----------------------------------------------------------------------------
module tb_irq_priority_ctrl;
    import irq_ctrl_pkg::*;

    localparam int NUM_SRC = 8;
    localparam int ID_W    = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_SRC-1:0] irq_src_i;
    logic [NUM_SRC-1:0] irq_en_i;
    logic               irq_o;
    logic [ID_W-1:0]    irq_id_o;
    logic               irq_ack_i;
    logic               irq_eoi_i;
    logic               irq_busy_o;
    logic [NUM_SRC-1:0] pending_o;
    logic [NUM_SRC-1:0] ovf_o;
    irq_state_e         dbg_state_o;

    int n_checks = 0;
    int n_err    = 0;
    logic [ID_W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    irq_priority_ctrl #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_src_i   (irq_src_i),
        .irq_en_i    (irq_en_i),
        .irq_o       (irq_o),
        .irq_id_o    (irq_id_o),
        .irq_ack_i   (irq_ack_i),
        .irq_eoi_i   (irq_eoi_i),
        .irq_busy_o  (irq_busy_o),
        .pending_o   (pending_o),
        .ovf_o       (ovf_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        irq_src_i = '0;
        repeat (4) tick();
    endtask

    task automatic wait_irq(input string tag, output int n);
        n = 0;
        while (irq_o !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_irq_seen"}, 32'(irq_o), 32'd1);
    endtask

    // Compares the queued expected ID, then acknowledges (optionally with eoi).
    task automatic ack_cycle(input string tag, input bit with_eoi);
        logic [ID_W-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s_sb: got id %0h with no expected entry", tag, irq_id_o);
        end else begin
            e = exp_q.pop_front();
            if (irq_id_o !== e) begin
                n_err++;
                $display("FAIL %s_id: got %0h expected %0h", tag, irq_id_o, e);
            end
        end
        irq_ack_i = 1'b1;
        irq_eoi_i = with_eoi;
        tick();
        irq_ack_i = 1'b0;
        irq_eoi_i = 1'b0;
        chk({tag, "_ack_irq"},   32'(irq_o),       32'd0);
        chk({tag, "_ack_busy"},  32'(irq_busy_o),  32'd1);
        chk({tag, "_ack_state"}, 32'(dbg_state_o), 32'(SERVICE));
    endtask

    task automatic eoi_cycle(input string tag);
        tick();
        tick();
        chk({tag, "_svc_state"}, 32'(dbg_state_o), 32'(SERVICE));
        irq_eoi_i = 1'b1;
        tick();
        irq_eoi_i = 1'b0;
        chk({tag, "_eoi_busy"},  32'(irq_busy_o),  32'd0);
        chk({tag, "_eoi_irq"},   32'(irq_o),       32'd0);
        chk({tag, "_eoi_state"}, 32'(dbg_state_o), 32'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [ID_W-1:0] g;
        rst_n     = 1'b0;
        irq_src_i = '0;
        irq_en_i  = '1;
        irq_ack_i = 1'b0;
        irq_eoi_i = 1'b0;
        #12;
        chk("rst_irq",     32'(irq_o),       32'd0);
        chk("rst_id",      32'(irq_id_o),    32'd0);
        chk("rst_busy",    32'(irq_busy_o),  32'd0);
        chk("rst_pending", 32'(pending_o),   32'd0);
        chk("rst_ovf",     32'(ovf_o),       32'd0);
        chk("rst_state",   32'(dbg_state_o), 32'(IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // ack in IDLE is ignored
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        chk("idle_ack_state", 32'(dbg_state_o), 32'(IDLE));

        // Source 3: latency, eoi in REQ ignored, ack+eoi takes only ack
        exp_q.push_back(3'd3);
        irq_src_i[3] = 1'b1;
        tick();
        tick();
        chk("t1_pending", 32'(pending_o), 32'h08);
        chk("t1_irq_t1",  32'(irq_o),     32'd0);
        wait_irq("t1", n);
        chk("t1_latency", 32'(n), 32'd1);
        irq_eoi_i = 1'b1;
        tick();
        irq_eoi_i = 1'b0;
        chk("t1_req_eoi_state", 32'(dbg_state_o), 32'(REQ));
        chk("t1_req_eoi_irq",   32'(irq_o),       32'd1);
        ack_cycle("t1", 1'b1);
        chk("t1_pend_clr", 32'(pending_o), 32'h00);
        eoi_cycle("t1");
        repeat (5) tick();
        chk("t1_one_edge", 32'(irq_o), 32'd0);

        // Sources 1 and 5 together
        settle();
`ifdef IRQ_ROUND_ROBIN_EN
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd1);
`else
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd5);
`endif
        irq_src_i[1] = 1'b1;
        irq_src_i[5] = 1'b1;
        wait_irq("t2a", n);
        ack_cycle("t2a", 1'b0);
        eoi_cycle("t2a");
        wait_irq("t2b", n);
        chk("t2_next_latency", 32'(n), 32'd1);
        ack_cycle("t2b", 1'b0);
        eoi_cycle("t2b");

        // Source 2 masked, then enabled
        settle();
        irq_en_i[2]  = 1'b0;
        irq_src_i[2] = 1'b1;
        repeat (4) tick();
        chk("t3_pending", 32'(pending_o), 32'h04);
        chk("t3_masked",  32'(irq_o),     32'd0);
        exp_q.push_back(3'd2);
        irq_en_i = '1;
        wait_irq("t3", n);
        chk("t3_unmask_latency", 32'(n), 32'd1);
        ack_cycle("t3", 1'b0);
        chk("t3_pend_clr", 32'(pending_o), 32'h00);
        eoi_cycle("t3");

        // Source 4 pulses twice before ack
        settle();
        exp_q.push_back(3'd4);
        irq_src_i[4] = 1'b1;
        tick();
        irq_src_i[4] = 1'b0;
        tick();
        irq_src_i[4] = 1'b1;
        tick();
        tick();
        chk("t4_ovf",     32'(ovf_o),     32'h10);
        chk("t4_pending", 32'(pending_o), 32'h10);
        wait_irq("t4", n);
        ack_cycle("t4", 1'b0);
        chk("t4_pend_clr", 32'(pending_o), 32'h00);
        chk("t4_ovf_clr",  32'(ovf_o),     32'h00);
        eoi_cycle("t4");

        // Edge on source 6 in the ack cycle for id 6
        settle();
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd6);
        irq_src_i[6] = 1'b1;
        tick();
        irq_src_i[6] = 1'b0;
        wait_irq("t5a", n);
        irq_src_i[6] = 1'b1;
        tick();
        ack_cycle("t5a", 1'b0);
        chk("t5_pend_kept", 32'(pending_o), 32'h40);
        chk("t5_no_ovf",    32'(ovf_o),     32'h00);
        eoi_cycle("t5a");
        wait_irq("t5b", n);
        chk("t5_rereq_latency", 32'(n), 32'd1);
        ack_cycle("t5b", 1'b0);
        chk("t5_pend_clr", 32'(pending_o), 32'h00);
        eoi_cycle("t5b");

        // Reset during SERVICE with an edge in flight
        settle();
        exp_q.push_back(3'd1);
        irq_src_i[1] = 1'b1;
        wait_irq("t6", n);
        ack_cycle("t6", 1'b0);
        irq_src_i[2] = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_irq",     32'(irq_o),       32'd0);
        chk("t6_rst_busy",    32'(irq_busy_o),  32'd0);
        chk("t6_rst_id",      32'(irq_id_o),    32'd0);
        chk("t6_rst_pending", 32'(pending_o),   32'd0);
        chk("t6_rst_state",   32'(dbg_state_o), 32'(IDLE));
        irq_src_i = '0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t6_post_pending", 32'(pending_o), 32'd0);
        chk("t6_post_irq",     32'(irq_o),     32'd0);

        // Sources 0 and 7 kept pending; each grant re-raises its own line
        for (int k = 0; k < 4; k++) begin
`ifdef IRQ_ROUND_ROBIN_EN
            exp_q.push_back((k % 2 == 0) ? 3'd7 : 3'd0);
`else
            exp_q.push_back(3'd0);
`endif
        end
        irq_src_i[0] = 1'b1;
        irq_src_i[7] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_irq("t7", n);
            g = (exp_q.size() != 0) ? exp_q[0] : 3'd0;
            ack_cycle("t7", 1'b0);
            irq_src_i[g] = 1'b0;
            tick();
            irq_src_i[g] = 1'b1;
            tick();
            tick();
            eoi_cycle("t7");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
